lc3_addr_gen: RTL and testbench

LC3_ADDR_GEN -- requirements
Module: lc3_addr_gen

---
 rtl/lc3_pkg.sv | 27 ++
 rtl/lc3_addr_gen_if.sv | 31 +++
 rtl/lc3_ext.sv | 16 +
 rtl/lc3_addr_gen.sv | 117 +++++++++++
 tb/tb_lc3_addr_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 address generator: mux selects and FSM state.
package lc3_pkg;

  localparam logic ADDR1_PC    = 1'b0;
  localparam logic ADDR1_SR1   = 1'b1;
  localparam logic MARMUX_ZEXT = 1'b0;
  localparam logic MARMUX_SUM  = 1'b1;

  typedef enum logic [1:0] {
    ADDR2_OFF11 = 2'b00,
    ADDR2_OFF9  = 2'b01,
    ADDR2_OFF6  = 2'b10,
    ADDR2_ZERO  = 2'b11
  } addr2_sel_e;

  typedef enum logic [1:0] {
    PCMUX_BUS  = 2'b00,
    PCMUX_SUM  = 2'b01,
    PCMUX_INC  = 2'b10,
    PCMUX_ZERO = 2'b11
  } pcmux_sel_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_EMPTY = 1'b0;
  localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/lc3_addr_gen_if.sv
// Command/result bundle between the control unit and the address generator.
interface lc3_addr_gen_if #(parameter int WIDTH = 16);
  logic [15:0]      ir;
  logic [WIDTH-1:0] sr1_out;
  logic [WIDTH-1:0] bus;
  logic             addr1mux_sel;
  logic [1:0]       addr2mux_sel;
  logic             marmux_sel;
  logic [1:0]       pcmux_sel;
  logic             ld_pc;
  logic             ld_mar;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] mar;

  modport master (
    output ir, sr1_out, bus, addr1mux_sel, addr2mux_sel, marmux_sel, pcmux_sel,
           ld_pc, ld_mar, in_valid, out_ready,
    input  in_ready, out_valid, result, pc, mar
  );

  modport slave (
    input  ir, sr1_out, bus, addr1mux_sel, addr2mux_sel, marmux_sel, pcmux_sel,
           ld_pc, ld_mar, in_valid, out_ready,
    output in_ready, out_valid, result, pc, mar
  );
endinterface

// File: rtl/lc3_ext.sv
// Field extender: sign- or zero-extends an IN_W field to OUT_W bits.
module lc3_ext #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out
);

  logic w_fill;

  assign w_fill = SIGNED ? i_in[IN_W-1] : 1'b0;
  assign o_out  = {{(OUT_W-IN_W){w_fill}}, i_in};

endmodule

// File: rtl/lc3_addr_gen.sv
// LC-3 address generator: ADDR1/ADDR2 adder, MARMUX/PCMUX, PC and MAR registers
// behind a one-deep valid/ready output stage.
//
//   state    | meaning
//   ---------+-----------------------------------------
//   ST_EMPTY | no result held, out_valid = 0
//   ST_FULL  | result holds an undelivered MARMUX value
module lc3_addr_gen
  import lc3_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = WIDTH'(16'h3000)
) (
  input logic           clk,
  input logic           reset,
  lc3_addr_gen_if.slave s
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_mar;
  logic [WIDTH-1:0] r_result;
  state_t           r_state;

  logic [WIDTH-1:0] w_sext11;
  logic [WIDTH-1:0] w_sext9;
  logic [WIDTH-1:0] w_sext6;
  logic [WIDTH-1:0] w_zext8;
  logic [WIDTH-1:0] w_addr1;
  logic [WIDTH-1:0] w_addr2;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_marmux;
  logic [WIDTH-1:0] w_pcmux;
  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_unused_ir;

  // Opcode bits never feed an offset field.
  assign w_unused_ir = ^s.ir[15:11];

  lc3_ext #(.IN_W(11), .OUT_W(WIDTH), .SIGNED(1'b1)) u_sext11 (
    .i_in (s.ir[10:0]),
    .o_out(w_sext11)
  );

  lc3_ext #(.IN_W(9), .OUT_W(WIDTH), .SIGNED(1'b1)) u_sext9 (
    .i_in (s.ir[8:0]),
    .o_out(w_sext9)
  );

  lc3_ext #(.IN_W(6), .OUT_W(WIDTH), .SIGNED(1'b1)) u_sext6 (
    .i_in (s.ir[5:0]),
    .o_out(w_sext6)
  );

  lc3_ext #(.IN_W(8), .OUT_W(WIDTH), .SIGNED(1'b0)) u_zext8 (
    .i_in (s.ir[7:0]),
    .o_out(w_zext8)
  );

  assign w_addr1 = (s.addr1mux_sel == ADDR1_SR1) ? s.sr1_out : r_pc;

  always_comb begin
    w_addr2 = '0;
    case (s.addr2mux_sel)
      ADDR2_OFF11: w_addr2 = w_sext11;
      ADDR2_OFF9:  w_addr2 = w_sext9;
      ADDR2_OFF6:  w_addr2 = w_sext6;
      ADDR2_ZERO:  w_addr2 = '0;
      default:     w_addr2 = '0;
    endcase
  end

  // Both sums wrap at WIDTH bits; the carry out is deliberately dropped.
  assign w_sum    = w_addr1 + w_addr2;
  assign w_pc_inc = r_pc + WIDTH'(1);
  assign w_marmux = (s.marmux_sel == MARMUX_SUM) ? w_sum : w_zext8;

  always_comb begin
    w_pcmux = '0;
    case (s.pcmux_sel)
      PCMUX_BUS:  w_pcmux = s.bus;
      PCMUX_SUM:  w_pcmux = w_sum;
      PCMUX_INC:  w_pcmux = w_pc_inc;
      PCMUX_ZERO: w_pcmux = '0;
      default:    w_pcmux = '0;
    endcase
  end

  assign w_out_valid = (r_state == ST_FULL);
  assign w_in_ready  = !w_out_valid || s.out_ready;
  assign w_accept    = s.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= PC_RESET;
      r_mar    <= '0;
      r_result <= '0;
      r_state  <= ST_EMPTY;
    end else if (w_accept) begin
      r_state  <= ST_FULL;
      r_result <= w_marmux;
      if (s.ld_mar) r_mar <= w_marmux;
      if (s.ld_pc)  r_pc  <= w_pcmux;
    end else if (s.out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = w_out_valid;
  assign s.result    = r_result;
  assign s.pc        = r_pc;
  assign s.mar       = r_mar;

endmodule

// File: tb/tb_lc3_addr_gen.sv
// Directed bench for lc3_addr_gen: a 16-bit instance for most scenarios and a
// 20-bit instance for the wide sign-extension case.
module tb_lc3_addr_gen;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  lc3_addr_gen_if #(.WIDTH(16)) if16 ();
  lc3_addr_gen_if #(.WIDTH(20)) if20 ();

  lc3_addr_gen #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .s(if16.slave));
  lc3_addr_gen #(.WIDTH(20)) dut20 (.clk(clk), .reset(reset), .s(if20.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd16(input logic a1, input logic [1:0] a2, input logic mm,
                       input logic [1:0] pm, input logic lp, input logic lm,
                       input logic [15:0] ir, input logic [15:0] sr1,
                       input logic [15:0] bus, input logic v, input logic ordy);
    if16.addr1mux_sel = a1;
    if16.addr2mux_sel = a2;
    if16.marmux_sel   = mm;
    if16.pcmux_sel    = pm;
    if16.ld_pc        = lp;
    if16.ld_mar       = lm;
    if16.ir           = ir;
    if16.sr1_out      = sr1;
    if16.bus          = bus;
    if16.in_valid     = v;
    if16.out_ready    = ordy;
  endtask

  task automatic test_reset();
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (if16.pc !== 16'h3000) begin n_err++; $display("FAIL reset_pc: got %h want 3000", if16.pc); end
    n_cmp++; if (if16.mar !== 16'h0) begin n_err++; $display("FAIL reset_mar: got %h want 0000", if16.mar); end
    n_cmp++; if (if16.result !== 16'h0) begin n_err++; $display("FAIL reset_result: got %h want 0000", if16.result); end
    n_cmp++; if (if16.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", if16.out_valid); end
    n_cmp++; if (if16.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", if16.in_ready); end
    n_cmp++; if (if20.pc !== 20'h03000) begin n_err++; $display("FAIL reset_pc20: got %h want 03000", if20.pc); end
  endtask

  task automatic test_marmux();
    // LEA: PC + SEXT(1FF) = 3000 - 1
    cmd16(0, 2'b01, 1, 2'b00, 0, 1, 16'h01FF, 16'h0, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.result !== 16'h2FFF) begin n_err++; $display("FAIL lea_result: got %h want 2fff", if16.result); end
    n_cmp++; if (if16.mar !== 16'h2FFF) begin n_err++; $display("FAIL lea_mar: got %h want 2fff", if16.mar); end
    n_cmp++; if (if16.out_valid !== 1'b1) begin n_err++; $display("FAIL lea_out_valid: got %b want 1", if16.out_valid); end
    n_cmp++; if (if16.pc !== 16'h3000) begin n_err++; $display("FAIL lea_pc_hold: got %h want 3000", if16.pc); end
    // base + SEXT(6'h20) = 1234 - 32
    cmd16(1, 2'b10, 1, 2'b00, 0, 1, 16'h0020, 16'h1234, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.mar !== 16'h1214) begin n_err++; $display("FAIL off6_mar: got %h want 1214", if16.mar); end
    cmd16(1, 2'b11, 0, 2'b00, 0, 0, 16'hFFF5, 16'hABCD, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.result !== 16'h00F5) begin n_err++; $display("FAIL zext_result: got %h want 00f5", if16.result); end
    n_cmp++; if (if16.mar !== 16'h1214) begin n_err++; $display("FAIL zext_mar_hold: got %h want 1214", if16.mar); end
    cmd16(1, 2'b11, 1, 2'b00, 0, 0, 16'hFFF5, 16'hABCD, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.result !== 16'hABCD) begin n_err++; $display("FAIL zero_off_result: got %h want abcd", if16.result); end
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
    n_cmp++; if (if16.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %b want 0", if16.out_valid); end
  endtask

  task automatic test_pc_paths();
    cmd16(0, 2'b00, 0, 2'b00, 1, 0, 16'h0, 16'h0, 16'hFFFF, 1, 1);
    tick();
    n_cmp++; if (if16.pc !== 16'hFFFF) begin n_err++; $display("FAIL pc_bus_load: got %h want ffff", if16.pc); end
    cmd16(0, 2'b00, 0, 2'b10, 1, 0, 16'h0, 16'h0, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.pc !== 16'h0000) begin n_err++; $display("FAIL pc_inc_wrap: got %h want 0000", if16.pc); end
    cmd16(0, 2'b00, 0, 2'b00, 1, 0, 16'h0, 16'h0, 16'h3000, 1, 1);
    tick();
    // PC and MAR both take PC+5 computed from the pre-update PC
    cmd16(0, 2'b01, 1, 2'b01, 1, 1, 16'h0005, 16'h0, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.pc !== 16'h3005) begin n_err++; $display("FAIL pc_sum: got %h want 3005", if16.pc); end
    n_cmp++; if (if16.mar !== 16'h3005) begin n_err++; $display("FAIL mar_old_pc: got %h want 3005", if16.mar); end
    cmd16(0, 2'b00, 0, 2'b11, 1, 1, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
    n_cmp++; if (if16.pc !== 16'h3005) begin n_err++; $display("FAIL pc_ld_ignored: got %h want 3005", if16.pc); end
    n_cmp++; if (if16.mar !== 16'h3005) begin n_err++; $display("FAIL mar_ld_ignored: got %h want 3005", if16.mar); end
    cmd16(0, 2'b00, 0, 2'b11, 1, 0, 16'h0, 16'h0, 16'h0, 1, 1);
    tick();
    n_cmp++; if (if16.pc !== 16'h0000) begin n_err++; $display("FAIL pc_zero: got %h want 0000", if16.pc); end
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
  endtask

  task automatic test_jsr_wide();
    if20.addr1mux_sel = 1'b0;
    if20.addr2mux_sel = 2'b00;
    if20.marmux_sel   = 1'b1;
    if20.pcmux_sel    = 2'b01;
    if20.ld_pc        = 1'b1;
    if20.ld_mar       = 1'b0;
    if20.ir           = 16'h0400;
    if20.in_valid     = 1'b1;
    if20.out_ready    = 1'b1;
    tick();
    if20.in_valid = 1'b0;
    if20.ld_pc    = 1'b0;
    n_cmp++; if (if20.pc !== 20'h02C00) begin n_err++; $display("FAIL jsr20_pc: got %h want 02c00", if20.pc); end
    n_cmp++; if (if20.result !== 20'h02C00) begin n_err++; $display("FAIL jsr20_result: got %h want 02c00", if20.result); end
  endtask

  task automatic test_back_to_back();
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0011, 16'h0, 16'h0, 1, 0);
    tick();
    n_cmp++; if (if16.result !== 16'h0011) begin n_err++; $display("FAIL bp_first_result: got %h want 0011", if16.result); end
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0022, 16'h0, 16'h0, 1, 0);
    #1;
    n_cmp++; if (if16.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %b want 0", if16.in_ready); end
    tick();
    n_cmp++; if (if16.result !== 16'h0011) begin n_err++; $display("FAIL bp_result_hold: got %h want 0011", if16.result); end
    n_cmp++; if (if16.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_hold: got %b want 1", if16.out_valid); end
    if16.out_ready = 1'b1;
    #1;
    n_cmp++; if (if16.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_drain: got %b want 1", if16.in_ready); end
    tick();
    n_cmp++; if (if16.result !== 16'h0022) begin n_err++; $display("FAIL bp_second_result: got %h want 0022", if16.result); end
    n_cmp++; if (if16.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_stay: got %b want 1", if16.out_valid); end
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
    tick();
    n_cmp++; if (if16.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_final_drain: got %b want 0", if16.out_valid); end
  endtask

  task automatic test_reset_mid();
    cmd16(0, 2'b00, 0, 2'b00, 1, 1, 16'h0033, 16'h0, 16'h4000, 1, 0);
    tick();
    n_cmp++; if (if16.pc !== 16'h4000) begin n_err++; $display("FAIL rm_pc_setup: got %h want 4000", if16.pc); end
    n_cmp++; if (if16.out_valid !== 1'b1) begin n_err++; $display("FAIL rm_full_setup: got %b want 1", if16.out_valid); end
    cmd16(0, 2'b00, 0, 2'b00, 1, 1, 16'h0077, 16'h0, 16'h5555, 1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd16(0, 2'b00, 0, 2'b00, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
    #1;
    n_cmp++; if (if16.pc !== 16'h3000) begin n_err++; $display("FAIL rm_pc: got %h want 3000", if16.pc); end
    n_cmp++; if (if16.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", if16.out_valid); end
    n_cmp++; if (if16.mar !== 16'h0) begin n_err++; $display("FAIL rm_mar: got %h want 0000", if16.mar); end
    n_cmp++; if (if16.result !== 16'h0) begin n_err++; $display("FAIL rm_result: got %h want 0000", if16.result); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    if20.addr1mux_sel = 1'b0;
    if20.addr2mux_sel = 2'b00;
    if20.marmux_sel   = 1'b0;
    if20.pcmux_sel    = 2'b00;
    if20.ld_pc        = 1'b0;
    if20.ld_mar       = 1'b0;
    if20.ir           = 16'h0;
    if20.sr1_out      = 20'h0;
    if20.bus          = 20'h0;
    if20.in_valid     = 1'b0;
    if20.out_ready    = 1'b0;
    test_reset();
    test_marmux();
    test_pc_paths();
    test_jsr_wide();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
